// File: rtl/clapper_pkg.sv
// Shared sizing constants, collector state type and abs helper for the FFT magnitude path.
package clapper_pkg;

   localparam int BIN_COUNT = 16;
   localparam int IN_W      = 16;
   localparam int MAG_W     = 16;
   localparam int CNT_W     = $clog2(BIN_COUNT);

   typedef enum logic {
      FILL = 1'b0,
      HOLD = 1'b1
   } collState_t;

   // One bit wider than the input so that |-32768| = 32768 is representable.
   function automatic logic [IN_W:0] absExt(input logic signed [IN_W-1:0] v);
      logic [IN_W:0] ext;
      ext = {v[IN_W-1], v};
      return v[IN_W-1] ? (~ext + {{IN_W{1'b0}}, 1'b1}) : ext;
   endfunction

endpackage

// File: rtl/fft_mag_abs.sv
// Combinational |re| + |im| magnitude estimate, saturated to the unsigned MAG_W range.
module fft_mag_abs
   import clapper_pkg::*;
(
   input  logic signed [IN_W-1:0]  re,
   input  logic signed [IN_W-1:0]  im,
   output logic        [MAG_W-1:0] mag
);

   logic [IN_W:0] absRe;
   logic [IN_W:0] absIm;
   logic [IN_W:0] magSum;

   // Each operand is at most 2^(IN_W-1), so the sum always fits in IN_W+1 bits.
   always_comb begin
      absRe  = absExt(re);
      absIm  = absExt(im);
      magSum = absRe + absIm;
      mag    = magSum[IN_W] ? {MAG_W{1'b1}} : magSum[MAG_W-1:0];
   end

endmodule

// File: rtl/fft_mag_collector.sv
// Collects 16 FFT bin magnitudes into a frame and holds it until the consumer takes it.
// Optional FFT_MAG_DC_BLANK_EN: bin 0 is stored as zero (sample still accepted and counted).
module fft_mag_collector
   import clapper_pkg::*;
(
   input  logic                         clk,
   input  logic                         reset,
   input  logic                         in_valid,
   output logic                         in_ready,
   input  logic signed [IN_W-1:0]       in_re,
   input  logic signed [IN_W-1:0]       in_im,
   input  logic                         in_last,
   output logic                         out_valid,
   input  logic                         out_ready,
   output logic [BIN_COUNT*MAG_W-1:0]   out_bins,
   output logic                         frame_err
);

   localparam logic [CNT_W-1:0] LAST_BIN = CNT_W'(BIN_COUNT - 1);

   collState_t       stateReg;
   collState_t       stateNext;
   logic [CNT_W-1:0] cntReg;
   logic [CNT_W-1:0] cntNext;
   logic             frameErrReg;
   logic             frameErrNext;
   logic             accept;
   logic [MAG_W-1:0] magValue;

   fft_mag_abs uMagAbs (
      .re  (in_re),
      .im  (in_im),
      .mag (magValue)
   );

   always_comb begin
      stateNext    = stateReg;
      cntNext      = cntReg;
      frameErrNext = 1'b0;
      in_ready     = (stateReg == FILL);
      out_valid    = (stateReg == HOLD);
      accept       = in_valid && (stateReg == FILL);

      case (stateReg)
         FILL: begin
            if (accept) begin
               if (cntReg == LAST_BIN) begin
                  // A full count always completes the frame; a missing last is only flagged.
                  stateNext    = HOLD;
                  cntNext      = '0;
                  frameErrNext = !in_last;
               end else if (in_last) begin
                  cntNext      = '0;
                  frameErrNext = 1'b1;
               end else begin
                  cntNext = cntReg + CNT_W'(1);
               end
            end
         end
         HOLD: begin
            if (out_ready) begin
               stateNext = FILL;
               cntNext   = '0;
            end
         end
         default: begin
            stateNext = FILL;
            cntNext   = '0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         stateReg    <= FILL;
         cntReg      <= '0;
         frameErrReg <= 1'b0;
      end else begin
         stateReg    <= stateNext;
         cntReg      <= cntNext;
         frameErrReg <= frameErrNext;
      end
   end

   assign frame_err = frameErrReg;

   // Bins are writable only in FILL, so out_bins is frozen for the whole of HOLD.
   generate
      for (genvar gi = 0; gi < BIN_COUNT; gi++) begin : gBin
         localparam logic [CNT_W-1:0] BIN_IDX = CNT_W'(gi);
`ifdef FFT_MAG_DC_BLANK_EN
         localparam bit BLANK = (gi == 0);
`else
         localparam bit BLANK = 1'b0;
`endif
         logic [MAG_W-1:0] binReg;

         always_ff @(posedge clk) begin
            if (reset) begin
               binReg <= '0;
            end else if (accept && (cntReg == BIN_IDX)) begin
               binReg <= BLANK ? '0 : magValue;
            end
         end

         assign out_bins[gi*MAG_W +: MAG_W] = binReg;
      end
   endgenerate

endmodule

// File: tb/tb_fft_mag_collector.sv
// Self-checking bench for fft_mag_collector: directed vector tables, corner sequences and a
// randomized run scored against a queue-based frame model.
module tb_fft_mag_collector;

   logic               clk = 1'b0;
   logic               reset;
   logic               in_valid;
   logic               in_ready;
   logic signed [15:0] in_re;
   logic signed [15:0] in_im;
   logic               in_last;
   logic               out_valid;
   logic               out_ready;
   logic [255:0]       out_bins;
   logic               frame_err;

   fft_mag_collector dut (
      .clk       (clk),
      .reset     (reset),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_re     (in_re),
      .in_im     (in_im),
      .in_last   (in_last),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_bins  (out_bins),
      .frame_err (frame_err)
   );

   always #5 clk = ~clk;

`ifdef FFT_MAG_DC_BLANK_EN
   localparam bit DC_BLANK = 1'b1;
`else
   localparam bit DC_BLANK = 1'b0;
`endif

   typedef struct {
      logic signed [15:0] re;
      logic signed [15:0] im;
      bit                 last;
      logic [15:0]        expMag;
   } vec_t;

   vec_t tblA[16];
   vec_t tblB[16];

   int assertCount = 0;
   int failCount   = 0;

   // Frame model: magnitudes collected so far, and the frame expected on out_bins.
   int pend[$];
   int expFrame[16];
   bit expHold = 1'b0;
   bit expErr  = 1'b0;

   function automatic int refMag(int re, int im);
      int s;
      s = (re < 0 ? -re : re) + (im < 0 ? -im : im);
      return (s > 65535) ? 65535 : s;
   endfunction

   function automatic logic [255:0] packFrame();
      logic [255:0] v;
      for (int i = 0; i < 16; i++) v[16*i +: 16] = 16'(expFrame[i]);
      return v;
   endfunction

   task automatic check(string name, logic [255:0] act, logic [255:0] exp);
      assertCount++;
      if (act !== exp) begin
         failCount++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic modelAccept(int re, int im, bit last);
      int m;
      m = refMag(re, im);
      if (DC_BLANK && pend.size() == 0) m = 0;
      pend.push_back(m);
      expErr = 1'b0;
      if (pend.size() == 16) begin
         for (int i = 0; i < 16; i++) expFrame[i] = pend[i];
         pend.delete();
         expHold = 1'b1;
         expErr  = !last;
      end else if (last) begin
         pend.delete();
         expErr = 1'b1;
      end
   endtask

   // Called and returns at a falling edge; the accept happens on the rising edge in between.
   task automatic sendSample(input logic signed [15:0] re, input logic signed [15:0] im,
                             input bit last);
      int waits = 0;
      in_valid = 1'b1;
      in_re    = re;
      in_im    = im;
      in_last  = last;
      while (in_ready !== 1'b1 && waits < 40) begin
         @(negedge clk);
         waits++;
      end
      if (waits >= 40) begin
         check("in_ready_timeout", {255'd0, in_ready}, 256'd1);
         in_valid = 1'b0;
         return;
      end
      @(negedge clk);
      in_valid = 1'b0;
      in_re    = 16'($urandom);
      in_im    = 16'($urandom);
      in_last  = 1'($urandom);
      modelAccept(int'(re), int'(im), last);
      $display("sample re=%0d im=%0d last=%0d queued=%0d", re, im, last, pend.size());
      check("frame_err", {255'd0, frame_err}, {255'd0, expErr});
      check("out_valid", {255'd0, out_valid}, {255'd0, expHold});
      check("in_ready", {255'd0, in_ready}, {255'd0, !expHold});
      if (expHold) check("out_bins", out_bins, packFrame());
   endtask

   task automatic consumeFrame(int holdCycles);
      out_ready = 1'b0;
      for (int c = 0; c < holdCycles; c++) begin
         in_valid = 1'b1;
         in_re    = 16'($urandom);
         in_im    = 16'($urandom);
         in_last  = 1'($urandom);
         @(negedge clk);
         check("hold_out_valid", {255'd0, out_valid}, 256'd1);
         check("hold_in_ready", {255'd0, in_ready}, 256'd0);
         check("hold_out_bins", out_bins, packFrame());
         check("hold_frame_err", {255'd0, frame_err}, 256'd0);
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      expHold   = 1'b0;
      check("release_in_ready", {255'd0, in_ready}, 256'd1);
      check("release_out_valid", {255'd0, out_valid}, 256'd0);
      $display("frame consumed after %0d stall cycles", holdCycles);
   endtask

   task automatic doReset();
      in_valid  = 1'b0;
      out_ready = 1'b0;
      reset     = 1'b1;
      @(negedge clk);
      check("rst_out_valid", {255'd0, out_valid}, 256'd0);
      check("rst_frame_err", {255'd0, frame_err}, 256'd0);
      check("rst_out_bins", out_bins, 256'd0);
      check("rst_in_ready", {255'd0, in_ready}, 256'd1);
      reset = 1'b0;
      pend.delete();
      expHold = 1'b0;
      expErr  = 1'b0;
      $display("reset applied");
   endtask

   task automatic setB(int i, int re, int im, int exp);
      tblB[i].re     = 16'(re);
      tblB[i].im     = 16'(im);
      tblB[i].last   = (i == 15);
      tblB[i].expMag = 16'(exp);
   endtask

   task automatic sendTableA(bit useLast);
      for (int k = 0; k < 16; k++) sendSample(tblA[k].re, tblA[k].im, useLast && tblA[k].last);
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not reach the end");
      $fatal(1, "simulation timeout");
   end

   initial begin
      for (int k = 0; k < 16; k++) begin
         tblA[k].re     = 16'(k);
         tblA[k].im     = 16'(-k);
         tblA[k].last   = (k == 15);
         tblA[k].expMag = 16'(2 * k);
      end
      setB(0, 100, 0, DC_BLANK ? 0 : 100);
      setB(1, 32767, 32767, 65534);
      setB(2, -32768, -1, 32769);
      setB(3, -32768, -32768, 65535);
      setB(4, -32768, 0, 32768);
      setB(5, 0, -32768, 32768);
      setB(6, -32767, -32767, 65534);
      setB(7, -32768, 32767, 65535);
      setB(8, 1, -32768, 32769);
      setB(9, 0, 0, 0);
      setB(10, -1, 0, 1);
      setB(11, 12345, -6789, 19134);
      setB(12, -20000, -20000, 40000);
      setB(13, 30000, -30000, 60000);
      setB(14, -32767, 32767, 65534);
      setB(15, -32768, 32767, 65535);

      reset     = 1'b1;
      in_valid  = 1'b0;
      in_re     = '0;
      in_im     = '0;
      in_last   = 1'b0;
      out_ready = 1'b0;
      repeat (2) @(negedge clk);
      check("init_out_valid", {255'd0, out_valid}, 256'd0);
      check("init_frame_err", {255'd0, frame_err}, 256'd0);
      check("init_out_bins", out_bins, 256'd0);
      check("init_in_ready", {255'd0, in_ready}, 256'd1);
      reset = 1'b0;

      // Ramp frame: bin k = 2k.
      sendTableA(1'b1);
      for (int k = 0; k < 16; k++) check("tblA_bin", out_bins[16*k +: 16], tblA[k].expMag);
      consumeFrame(2);

      // Extreme values and saturation boundary, then a 10-cycle stall.
      for (int k = 0; k < 16; k++) sendSample(tblB[k].re, tblB[k].im, tblB[k].last);
      for (int k = 0; k < 16; k++) check("tblB_bin", out_bins[16*k +: 16], tblB[k].expMag);
      consumeFrame(10);

      // Early last on the 5th sample: single error pulse, partial frame discarded.
      for (int k = 0; k < 5; k++) sendSample(16'(k + 7), 16'(-3), k == 4);
      @(negedge clk);
      check("early_err_cleared", {255'd0, frame_err}, 256'd0);
      check("early_no_valid", {255'd0, out_valid}, 256'd0);
      sendTableA(1'b1);
      for (int k = 0; k < 16; k++) check("after_early_bin", out_bins[16*k +: 16], tblA[k].expMag);
      consumeFrame(0);

      // Missing last: frame still completes, error flagged.
      sendTableA(1'b0);
      consumeFrame(1);

      // Reset after 8 accepts, then a fresh frame.
      for (int k = 0; k < 8; k++) sendSample(16'(1000 + k), 16'(-500), 1'b0);
      doReset();
      sendTableA(1'b1);
      for (int k = 0; k < 16; k++) check("post_rst_bin", out_bins[16*k +: 16], tblA[k].expMag);
      consumeFrame(1);

      // Reset while holding a frame discards it.
      for (int k = 0; k < 16; k++) sendSample(tblB[k].re, tblB[k].im, tblB[k].last);
      doReset();

      // Randomized traffic with occasional early/missing last and random stalls.
      for (int n = 0; n < 400; n++) begin
         logic signed [15:0] re;
         logic signed [15:0] im;
         bit                 last;
         repeat ($urandom_range(0, 2)) begin
            in_re   = 16'($urandom);
            in_im   = 16'($urandom);
            in_last = 1'($urandom);
            @(negedge clk);
         end
         re = ($urandom_range(0, 7) == 0) ? 16'sh8000 : 16'($urandom);
         im = ($urandom_range(0, 7) == 0) ? 16'sh8000 : 16'($urandom);
         if (pend.size() == 15) last = ($urandom_range(0, 19) != 0);
         else                   last = ($urandom_range(0, 29) == 0);
         sendSample(re, im, last);
         if (expHold) consumeFrame($urandom_range(0, 3));
      end

      $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
      $finish;
   end

endmodule

// File: doc/fft_mag_collector.md
FFT_MAG_COLLECTOR -- requirements
Module: fft_mag_collector

Interface
REQ-001 SHALL have port clk, input, 1, the single clock; all logic on its rising edge.
REQ-002 SHALL have port reset, input, 1, synchronous active-high reset.
REQ-003 SHALL have port in_valid, input, 1, FFT sample present.
REQ-004 SHALL have port in_ready, output, 1, collector accepts a sample this cycle.
REQ-005 SHALL have port in_re, input, 16, signed two's-complement real part.
REQ-006 SHALL have port in_im, input, 16, signed two's-complement imaginary part.
REQ-007 SHALL have port in_last, input, 1, marks the final sample of an FFT frame.
REQ-008 SHALL have port out_valid, output, 1, full 16-bin magnitude frame available.
REQ-009 SHALL have port out_ready, input, 1, downstream max-finder stage consumes the frame.
REQ-010 SHALL have port out_bins, output, 256, bin k magnitude (unsigned) at bits [16k+15:16k].
REQ-011 SHALL have port frame_err, output, 1, one-cycle pulse on frame-length mismatch.

Function
REQ-012 SHALL accept a sample only when in_valid and in_ready are both 1.
REQ-013 SHALL compute magnitude as |in_re|+|in_im| in 17 bits, saturated to 16'hFFFF; |-32768| = 32768.
REQ-014 SHALL write each accepted magnitude to bin[cnt], where cnt is a 4-bit bin counter; cnt then increments.
REQ-015 SHALL implement two states, FILL and HOLD; in_ready = 1 only in FILL; out_valid = 1 only in HOLD.
REQ-016 SHALL go FILL->HOLD on the accept with cnt==15; out_valid rises the next cycle, with all 16 bins stable.
REQ-017 SHALL hold out_bins constant throughout HOLD.
REQ-018 SHALL go HOLD->FILL on the cycle out_valid and out_ready are both 1, clearing cnt to 0; in_ready is 1 the following cycle.
REQ-019 SHALL, on an accepted in_last with cnt!=15, discard the partial frame, set cnt to 0, stay in FILL, and pulse frame_err the next cycle.
REQ-020 SHALL, on an accept with cnt==15 and in_last=0, still complete the frame (enter HOLD) and pulse frame_err the next cycle.
REQ-021 SHALL ignore in_re, in_im and in_last whenever no sample is accepted.

Reset
REQ-022 SHALL, while reset is high, set state=FILL, cnt=0, all bins=0, out_valid=0, frame_err=0; in_ready is 1 the first cycle after reset.
REQ-023 SHALL let reset override every transition, including mid-frame and during HOLD, discarding held data.

Configuration
REQ-024 SHALL honour macro FFT_MAG_DC_BLANK_EN: when defined, bin 0 is always stored as 0, but the bin-0 sample is still accepted and counted; when undefined, bin 0 stores its computed magnitude.

Structure
REQ-025 SHALL take BIN_COUNT=16, IN_W=16, MAG_W=16 and the FILL/HOLD state typedef from shared package clapper_pkg.
REQ-026 SHALL place the abs-sum-saturate logic in combinational sub-module fft_mag_abs.

Verification
REQ-027 SHALL cover: 16 samples with re=k, im=-k, last on the 16th -> out_valid 1 cycle later, bin k = 2k, frame_err=0.
REQ-028 SHALL cover: re=-32768, im=-32768 in bin 3 -> bin 3 = 16'hFFFF; re=-32768, im=0 -> 16'h8000.
REQ-029 SHALL cover: in_last on the 5th sample -> frame_err pulses once, no out_valid, and the next 16 samples form a clean frame.
REQ-030 SHALL cover: out_ready held 0 for 10 cycles during HOLD -> in_ready=0 and out_bins unchanged; out_ready=1 -> in_ready=1 next cycle.
REQ-031 SHALL cover: reset asserted after 8 accepts -> all outputs at reset values; 16 fresh samples then produce a correct frame.
REQ-032 SHALL cover: with FFT_MAG_DC_BLANK_EN defined, bin 0 sample re=100 -> bin 0 = 0; without it -> bin 0 = 100.
